// File: rtl/spi_flash_reader_if.sv
// Request/response and SPI pin bundle for the serial flash byte reader.
// master: requester side plus the flash device (drives request and MISO).
// slave:  the reader itself.
interface spi_flash_reader_if;
  logic        fd_valid;
  logic [23:0] fd_address;
  logic [7:0]  fd;
  logic        fd_ready;
  logic        busy;
  logic        spi_ss_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    output fd_valid, fd_address, spi_miso,
    input  fd, fd_ready, busy, spi_ss_n, spi_sclk, spi_mosi
  );

  modport slave (
    input  fd_valid, fd_address, spi_miso,
    output fd, fd_ready, busy, spi_ss_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master reading one byte from serial flash per request.
// Optional macro FAST_READ_EN: use the fast-read opcode with 8 dummy SCLK
// periods after the address (48 SCLK periods per frame instead of 40).
//
// state   | meaning
// IDLE    | waiting for fd_valid; SPI pins quiet
// SHIFT   | first cycle asserts chip select, then clocks command/address/data
// RECOVER | chip select high for 2*CLK_DIV cycles before the next request
module spi_flash_reader #(
  parameter int         CLK_DIV  = 4,
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter logic [7:0] CMD_FAST = 8'h0B
) (
  input logic                clk,
  input logic                rstn,
  spi_flash_reader_if.slave  bus
);

`ifdef FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [7:0] OPCODE     = FAST ? CMD_FAST : CMD_READ;
  // first SCLK period whose rising edge carries a data bit
  localparam logic [5:0] DATA_START = FAST ? 6'd40 : 6'd32;
  localparam logic [5:0] LAST_BIT   = DATA_START + 6'd7;

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int RW = $clog2(2 * CLK_DIV + 1);
  localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_DIV - 1);
  localparam logic [RW-1:0] REC_RELOAD  = RW'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, RECOVER} state_t;

  state_t        state, state_next;
  logic [31:0]   shreg;
  logic [7:0]    rx;
  logic [5:0]    bit_cnt;
  logic [HW-1:0] half_cnt;
  logic [RW-1:0] rec_cnt;
  logic          sclk, ss_n, mosi;
  logic [7:0]    fd_hold;
  logic          ready_pulse, busy_flag;

  logic accept, start, run, tick_rise, tick_fall, done, rec_done;

  assign bus.fd       = fd_hold;
  assign bus.fd_ready = ready_pulse;
  assign bus.busy     = busy_flag;
  assign bus.spi_ss_n = ss_n;
  assign bus.spi_sclk = sclk;
  assign bus.spi_mosi = mosi;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    start      = 1'b0;
    run        = 1'b0;
    tick_rise  = 1'b0;
    tick_fall  = 1'b0;
    done       = 1'b0;
    rec_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fd_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // chip select is still high only in the cycle right after acceptance
        if (ss_n) begin
          start = 1'b1;
        end else begin
          run = 1'b1;
          if (half_cnt == '0) begin
            tick_rise = ~sclk;
            tick_fall = sclk;
            if (sclk && bit_cnt == LAST_BIT) begin
              done       = 1'b1;
              state_next = RECOVER;
            end
          end
        end
      end
      RECOVER: begin
        if (rec_cnt == '0) begin
          rec_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // shift datapath, SPI pins, timers and result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg       <= '0;
      rx          <= '0;
      bit_cnt     <= '0;
      half_cnt    <= '0;
      rec_cnt     <= '0;
      sclk        <= 1'b0;
      ss_n        <= 1'b1;
      mosi        <= 1'b0;
      fd_hold     <= 8'h00;
      ready_pulse <= 1'b0;
      busy_flag   <= 1'b0;
    end else begin
      ready_pulse <= 1'b0;
      if (accept) begin
        shreg     <= {OPCODE, bus.fd_address};
        busy_flag <= 1'b1;
      end
      if (start) begin
        ss_n     <= 1'b0;
        mosi     <= shreg[31];
        half_cnt <= HALF_RELOAD;
        bit_cnt  <= '0;
      end
      if (run) begin
        half_cnt <= (half_cnt == '0) ? HALF_RELOAD : half_cnt - 1'b1;
      end
      if (tick_rise) begin
        sclk <= 1'b1;
        if (bit_cnt >= DATA_START) rx <= {rx[6:0], bus.spi_miso};
      end
      if (tick_fall) begin
        sclk <= 1'b0;
        if (done) begin
          ss_n        <= 1'b1;
          mosi        <= 1'b0;
          fd_hold     <= rx;
          ready_pulse <= 1'b1;
          rec_cnt     <= REC_RELOAD;
        end else begin
          // zeros shifted in give MOSI=0 through dummy and data phases
          mosi    <= shreg[30];
          shreg   <= {shreg[30:0], 1'b0};
          bit_cnt <= bit_cnt + 6'd1;
        end
      end
      if (state == RECOVER && rec_cnt != '0) rec_cnt <= rec_cnt - 1'b1;
      if (rec_done) busy_flag <= 1'b0;
    end
  end

endmodule
